// File: rtl/mac_stream_driver.sv
// Host-side stream driver: streams a buffered INPUT_DIM-word vector out as an
// AXI-Stream master and optionally collects a HIDDEN_UNITS-word result stream.
module mac_stream_driver #(
  parameter  int DATA_WIDTH   = 32,
  parameter  int INPUT_DIM    = 64,
  parameter  int HIDDEN_UNITS = 64,
  localparam int IW           = $clog2(INPUT_DIM),
  localparam int HW           = $clog2(HIDDEN_UNITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_wr_en,
  input  logic [IW-1:0]         in_wr_addr,
  input  logic [DATA_WIDTH-1:0] in_wr_data,
  input  logic                  start,
  input  logic                  send_only,
  output logic                  busy,
  output logic                  done,
  output logic                  err_tlast,
  input  logic [HW-1:0]         res_rd_addr,
  output logic [DATA_WIDTH-1:0] res_rd_data,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready
);

  typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

  localparam logic [IW-1:0] SEND_LAST = IW'(INPUT_DIM - 1);
  localparam logic [HW-1:0] RECV_LAST = HW'(HIDDEN_UNITS - 1);

  state_t                  state;
  logic [IW-1:0]           send_idx;
  logic [HW-1:0]           recv_idx;
  logic                    send_only_q;
  logic [DATA_WIDTH-1:0]   in_buf  [INPUT_DIM];
  logic [DATA_WIDTH-1:0]   res_buf [HIDDEN_UNITS];
  logic                    m_hs;
  logic                    s_hs;

  assign m_hs = m_axis_tvalid & m_axis_tready;
  assign s_hs = s_axis_tvalid & s_axis_tready;

  // Buffer writes are locked out while busy, so tdata is stable through stalls.
  assign m_axis_tdata = in_buf[send_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      send_idx      <= '0;
      recv_idx      <= '0;
      send_only_q   <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      s_axis_tready <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_tlast     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state         <= SEND;
            send_only_q   <= send_only;
            err_tlast     <= 1'b0;
            send_idx      <= '0;
            recv_idx      <= '0;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= 1'b0;
            busy          <= 1'b1;
          end
        end
        SEND: begin
          if (m_hs) begin
            if (send_idx == SEND_LAST) begin
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              if (send_only_q) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state         <= RECV;
                s_axis_tready <= 1'b1;
              end
            end else begin
              send_idx     <= send_idx + IW'(1);
              m_axis_tlast <= ((send_idx + IW'(1)) == SEND_LAST);
            end
          end
        end
        RECV: begin
          if (s_hs) begin
            // tlast must coincide exactly with the final word; either mismatch is flagged.
            if (s_axis_tlast || (recv_idx == RECV_LAST)) begin
              state         <= DONE;
              s_axis_tready <= 1'b0;
              busy          <= 1'b0;
              done          <= 1'b1;
              err_tlast     <= err_tlast | (s_axis_tlast != (recv_idx == RECV_LAST));
            end else begin
              recv_idx <= recv_idx + HW'(1);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && (state == IDLE) && in_wr_en)
      in_buf[in_wr_addr] <= in_wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst && (state == RECV) && s_hs)
      res_buf[recv_idx] <= s_axis_tdata;
  end

  always_ff @(posedge clk) begin
    if (rst)
      res_rd_data <= '0;
    else
      res_rd_data <= res_buf[res_rd_addr];
  end

endmodule

// File: tb/tb_mac_stream_driver.sv
// Bench for mac_stream_driver: randomized transfers checked against a
// transaction-level model of the vector/result buffers and the handshake rules.
module tb_mac_stream_driver;

  localparam int DW  = 32;
  localparam int IN  = 64;
  localparam int HID = 64;
  localparam int IW  = $clog2(IN);
  localparam int HW  = $clog2(HID);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_wr_en;
  logic [IW-1:0] in_wr_addr;
  logic [DW-1:0] in_wr_data;
  logic          start;
  logic          send_only;
  logic          busy;
  logic          done;
  logic          err_tlast;
  logic [HW-1:0] res_rd_addr;
  logic [DW-1:0] res_rd_data;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;

  always #5 clk = ~clk;

  mac_stream_driver #(
    .DATA_WIDTH  (DW),
    .INPUT_DIM   (IN),
    .HIDDEN_UNITS(HID)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_wr_en     (in_wr_en),
    .in_wr_addr   (in_wr_addr),
    .in_wr_data   (in_wr_data),
    .start        (start),
    .send_only    (send_only),
    .busy         (busy),
    .done         (done),
    .err_tlast    (err_tlast),
    .res_rd_addr  (res_rd_addr),
    .res_rd_data  (res_rd_data),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready)
  );

  int            n_assert = 0;
  int            n_fail   = 0;
  logic [DW-1:0] in_model  [IN];
  logic [DW-1:0] res_model [HID];
  logic [DW-1:0] rx_word   [HID];
  logic          exp_err;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // mode 0: word i = i+1; mode 1: random words. Address 5 is written twice.
  task automatic load_vec(input int mode);
    logic [DW-1:0] d;
    for (int i = 0; i < IN; i++) begin
      @(negedge clk);
      d = (mode == 0) ? DW'(i + 1) : DW'($urandom);
      in_wr_en   = 1'b1;
      in_wr_addr = IW'(i);
      in_wr_data = d;
      in_model[i] = d;
    end
    if (mode != 0) begin
      @(negedge clk);
      d = DW'($urandom);
      in_wr_addr  = IW'(5);
      in_wr_data  = d;
      in_model[5] = d;
    end
    @(negedge clk);
    in_wr_en = 1'b0;
  endtask

  // rdy_mode: 0 always ready, 1 toggling, 2 random. last_pos: word carrying
  // s_axis_tlast (HID means never). rst_at >= 0 resets after that many beats.
  // poke drives start/in_wr_en while busy and in the done cycle.
  task automatic run_xfer(input bit so, input int rdy_mode, input int last_pos,
                          input int rst_at, input bit poke, input bit rx_rand);
    int sent;
    int rcvd;
    bit pend_done;
    bit finished;
    bit exp_srdy;
    for (int k = 0; k < HID; k++)
      rx_word[k] = rx_rand ? DW'($urandom) : (32'h100 + DW'(k));
    @(negedge clk);
    start     = 1'b1;
    send_only = so;
    sent      = 0;
    rcvd      = 0;
    pend_done = 1'b0;
    finished  = 1'b0;
    exp_err   = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      start     = 1'b0;
      send_only = 1'b0;
      in_wr_en  = 1'b0;
      if (rst_at >= 0 && sent == rst_at) begin
        rst           = 1'b1;
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chkb("rst_tvalid", m_axis_tvalid, 1'b0);
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_done", done, 1'b0);
        chkb("rst_s_tready", s_axis_tready, 1'b0);
        chkb("rst_err", err_tlast, 1'b0);
        finished = 1'b1;
        break;
      end
      exp_srdy = !so && (sent == IN) && !pend_done;
      chkb("done", done, pend_done);
      chkb("busy", busy, !pend_done);
      chkb("m_tvalid", m_axis_tvalid, sent < IN);
      if (sent < IN) begin
        chk("m_tdata", m_axis_tdata, in_model[sent]);
        chkb("m_tlast", m_axis_tlast, sent == IN - 1);
      end
      chkb("s_tready", s_axis_tready, exp_srdy);
      chkb("err_tlast", err_tlast, exp_err);
      if (pend_done) begin
        finished = 1'b1;
        break;
      end
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = (cyc % 2 == 0);
        default: m_axis_tready = ($urandom % 3 != 0);
      endcase
      s_axis_tvalid = (rcvd < HID) && ($urandom % 4 != 0);
      s_axis_tdata  = (rcvd < HID) ? rx_word[rcvd] : '0;
      s_axis_tlast  = (rcvd == last_pos);
      if (poke && ($urandom % 5 == 0)) begin
        in_wr_en   = 1'b1;
        in_wr_addr = IW'($urandom);
        in_wr_data = DW'($urandom);
      end
      if (poke && ($urandom % 7 == 0)) start = 1'b1;
      if (sent < IN && m_axis_tready) begin
        sent++;
        if (sent == IN && so) pend_done = 1'b1;
      end else if (exp_srdy && s_axis_tvalid) begin
        res_model[rcvd] = rx_word[rcvd];
        if (s_axis_tlast != (rcvd == HID - 1)) exp_err = 1'b1;
        if (s_axis_tlast || rcvd == HID - 1) pend_done = 1'b1;
        rcvd++;
      end
    end
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (!finished) chkb("timeout", 1'b0, 1'b1);
    if (rst_at < 0) begin
      // Inputs during the done cycle must be ignored.
      start = poke;
      if (poke) begin
        in_wr_en   = 1'b1;
        in_wr_addr = IW'($urandom);
        in_wr_data = DW'($urandom);
      end
      @(negedge clk);
      start    = 1'b0;
      in_wr_en = 1'b0;
      chkb("idle_tvalid", m_axis_tvalid, 1'b0);
      chkb("idle_busy", busy, 1'b0);
      chkb("idle_done", done, 1'b0);
      chkb("idle_err", err_tlast, exp_err);
      for (int i = 0; i < HID; i++) begin
        res_rd_addr = HW'(i);
        @(negedge clk);
        chk("res_rd_data", res_rd_data, res_model[i]);
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    in_wr_en      = 1'b0;
    in_wr_addr    = '0;
    in_wr_data    = '0;
    start         = 1'b0;
    send_only     = 1'b0;
    res_rd_addr   = '0;
    m_axis_tready = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    exp_err       = 1'b0;
    repeat (3) @(negedge clk);
    chkb("reset_tvalid", m_axis_tvalid, 1'b0);
    chkb("reset_tlast", m_axis_tlast, 1'b0);
    chkb("reset_s_tready", s_axis_tready, 1'b0);
    chkb("reset_busy", busy, 1'b0);
    chkb("reset_done", done, 1'b0);
    chkb("reset_err", err_tlast, 1'b0);
    chk("reset_res_rd_data", res_rd_data, '0);
    rst = 1'b0;

    load_vec(0);
    run_xfer(1'b0, 0, HID - 1, -1, 1'b0, 1'b0);   // counting vector, 0x100+i results
    load_vec(1);
    run_xfer(1'b0, 1, HID - 1, -1, 1'b0, 1'b1);   // tready toggling every cycle
    run_xfer(1'b1, 2, HID - 1, -1, 1'b0, 1'b1);   // send only
    run_xfer(1'b0, 2, 9, -1, 1'b0, 1'b1);         // early tlast on word 9
    run_xfer(1'b0, 2, HID - 1, -1, 1'b0, 1'b1);   // start clears err_tlast
    run_xfer(1'b0, 0, HID, -1, 1'b0, 1'b1);       // tlast missing on final word
    run_xfer(1'b0, 0, HID - 1, 20, 1'b0, 1'b1);   // reset mid-send at beat 20
    run_xfer(1'b0, 2, HID - 1, -1, 1'b0, 1'b1);   // resend from word 0
    run_xfer(1'b0, 2, HID - 1, -1, 1'b1, 1'b1);   // start/writes while busy
    run_xfer(1'b1, 0, HID - 1, -1, 1'b0, 1'b0);   // buffer untouched by those writes

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
